cache_mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache and data-cache miss/write-through paths.
- Arbitrates round-robin between the two requesters.
- Sequences each access through a fixed-latency memory: issue, wait, respond.
- Returns read data to the winner with a one-cycle ready pulse.
- Sits between the two 4-way cache instances and the memory model.

---
 rtl/cache_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter.
//   arb_state_t : access sequencer state (idle, memory access, response)
//   arb_gnt_t   : which requester owns the current access
//   CNT_W       : width of the memory latency counter (latency 1..15)
package cache_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef enum logic {GNT_ICACHE, GNT_DCACHE} arb_gnt_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : bit 0 = I-cache, bit 1 = D-cache
//   advance    : a grant is being taken this cycle
//   gnt[1:0]   : one-hot grant (combinational)
// The pointer names the requester that wins a tie. It resets to the
// D-cache and moves to the loser only when both requesters were present
// at a taken grant; a lone requester leaves it where it is.
module rr_arb2
    import cache_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    arb_gnt_t ptr;

    always_comb begin
        gnt = req;
        if (&req)
            gnt = (ptr == GNT_DCACHE) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= GNT_DCACHE;
        else if (advance && (&req))
            ptr <= (ptr == GNT_DCACHE) ? GNT_ICACHE : GNT_DCACHE;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one fixed-latency memory port between the I-cache (reads only)
// and the D-cache (refill reads and write-through stores).
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   icache_req/addr           : I-cache read request, held until ready
//   icache_ready/rdata        : one-cycle completion pulse with read data
//   dcache_req/we/addr/wdata  : D-cache request, held until ready
//   dcache_ready/rdata        : one-cycle completion pulse with read data
//   mem_req/we/addr/wdata     : memory access, held MEM_LATENCY cycles
//   mem_rdata_i               : memory data, valid in the last access cycle
// Optional (macro ARB_PERF_CNT_EN): icache_grants_o / dcache_grants_o,
// 32-bit wrapping grant counters.
// Each access runs IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP (1 cycle),
// so one access completes every MEM_LATENCY+2 cycles.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MEM_LATENCY = 3
)
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             icache_req_i,
    input  logic [WIDTH-1:0] icache_addr_i,
    output logic             icache_ready_o,
    output logic [WIDTH-1:0] icache_rdata_o,
    input  logic             dcache_req_i,
    input  logic             dcache_we_i,
    input  logic [WIDTH-1:0] dcache_addr_i,
    input  logic [WIDTH-1:0] dcache_wdata_i,
    output logic             dcache_ready_o,
    output logic [WIDTH-1:0] dcache_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]      icache_grants_o,
    output logic [31:0]      dcache_grants_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       state;
    arb_gnt_t         owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             take;

    assign req  = {dcache_req_i, icache_req_i};
    assign take = (state == ARB_IDLE) && (|req);

    rr_arb2 u_arb (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .req     (req),
        .advance (take),
        .gnt     (gnt)
    );

    // The mem_* output registers double as the latched request: requester
    // inputs are not looked at again until the sequencer is back in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ARB_IDLE;
            owner          <= GNT_DCACHE;
            cnt            <= '0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            icache_ready_o <= 1'b0;
            icache_rdata_o <= '0;
            dcache_ready_o <= 1'b0;
            dcache_rdata_o <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (|gnt) begin
                        owner       <= gnt[1] ? GNT_DCACHE : GNT_ICACHE;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= gnt[1] & dcache_we_i;
                        mem_addr_o  <= gnt[1] ? dcache_addr_i : icache_addr_i;
                        mem_wdata_o <= gnt[1] ? dcache_wdata_i : '0;
                        cnt         <= CNT_LOAD;
                        state       <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt == '0) begin
                        // Stores return zero data; reads take the memory word
                        // present in the final access cycle.
                        if (owner == GNT_DCACHE) begin
                            dcache_ready_o <= 1'b1;
                            dcache_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                        end else begin
                            icache_ready_o <= 1'b1;
                            icache_rdata_o <= mem_rdata_i;
                        end
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        state       <= ARB_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    icache_ready_o <= 1'b0;
                    icache_rdata_o <= '0;
                    dcache_ready_o <= 1'b0;
                    dcache_rdata_o <= '0;
                    state          <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            icache_grants_o <= '0;
            dcache_grants_o <= '0;
        end else if (state == ARB_IDLE) begin
            if (gnt[0]) icache_grants_o <= icache_grants_o + 32'd1;
            if (gnt[1]) dcache_grants_o <= dcache_grants_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized and directed bench for cache_mem_arbiter against a
// transaction-level reference: each grant is a timestamp, memory activity
// spans the MEM_LATENCY cycles after it and the ready pulse follows.
module tb_cache_mem_arbiter;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (MEM_LATENCY=3)
    logic         ireq = 0, dreq = 0, dwe = 0;
    logic [W-1:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
    logic         irdy, drdy, mreq, mwe;
    logic [W-1:0] irdata, drdata, maddr, mwdata;

    // Second instance (MEM_LATENCY=1)
    logic         i1req = 0, d1req = 0, d1we = 0;
    logic [W-1:0] i1addr = '0, d1addr = '0, d1wdata = '0, m1rdata = '0;
    logic         i1rdy, d1rdy, m1req, m1we;
    logic [W-1:0] i1rdata, d1rdata, m1addr, m1wdata;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] igr, dgr, igr1, dgr1;
`endif

    cache_mem_arbiter #(.WIDTH(W), .MEM_LATENCY(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .icache_req_i(ireq), .icache_addr_i(iaddr),
        .icache_ready_o(irdy), .icache_rdata_o(irdata),
        .dcache_req_i(dreq), .dcache_we_i(dwe), .dcache_addr_i(daddr),
        .dcache_wdata_i(dwdata), .dcache_ready_o(drdy), .dcache_rdata_o(drdata),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr),
        .mem_wdata_o(mwdata), .mem_rdata_i(mrdata)
`ifdef ARB_PERF_CNT_EN
        , .icache_grants_o(igr), .dcache_grants_o(dgr)
`endif
    );

    cache_mem_arbiter #(.WIDTH(W), .MEM_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .icache_req_i(i1req), .icache_addr_i(i1addr),
        .icache_ready_o(i1rdy), .icache_rdata_o(i1rdata),
        .dcache_req_i(d1req), .dcache_we_i(d1we), .dcache_addr_i(d1addr),
        .dcache_wdata_i(d1wdata), .dcache_ready_o(d1rdy), .dcache_rdata_o(d1rdata),
        .mem_req_o(m1req), .mem_we_o(m1we), .mem_addr_o(m1addr),
        .mem_wdata_o(m1wdata), .mem_rdata_i(m1rdata)
`ifdef ARB_PERF_CNT_EN
        , .icache_grants_o(igr1), .dcache_grants_o(dgr1)
`endif
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference state: grant timestamp, winner, latched request
    int           k = 0, g = 0;
    bit           busy = 0, win_d = 0, ptr_d = 1;
    bit           m_we = 0;
    logic [W-1:0] m_addr = '0, m_wdata = '0, m_cap = '0;
    int           pi = 0, pd = 0;
    bit           hold_i = 0, hold_d = 0, rearm_i = 0, rearm_d = 0, rnd = 0;

    task automatic model_reset();
        busy = 0; ptr_d = 1; pi = 0; pd = 0;
        ireq = 0; dreq = 0; rearm_i = 0; rearm_d = 0;
    endtask

    task automatic cycle();
        bit act, rdy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            k++;
            if (busy && k == g + LAT) m_cap = m_we ? '0 : mrdata;
            if (busy && k == g + LAT + 1) begin
                busy = 0;
            end else if (!busy && (ireq || dreq)) begin
                win_d = (ireq && dreq) ? ptr_d : dreq;
                if (ireq && dreq) ptr_d = !ptr_d;
                busy    = 1;
                g       = k;
                m_addr  = win_d ? daddr : iaddr;
                m_we    = win_d && dwe;
                m_wdata = win_d ? dwdata : '0;
                if (win_d) pd++; else pi++;
            end
        end
        @(negedge clk);
        act = busy && k >= g && k < g + LAT;
        rdy = busy && k == g + LAT;
        chk("mem_req", mreq, act);
        chk("mem_we", mwe, act && m_we);
        chk("mem_addr", maddr, act ? m_addr : '0);
        chk("mem_wdata", mwdata, act ? m_wdata : '0);
        chk("i_ready", irdy, rdy && !win_d);
        chk("d_ready", drdy, rdy && win_d);
        chk("i_rdata", irdata, (rdy && !win_d) ? m_cap : '0);
        chk("d_rdata", drdata, (rdy && win_d) ? m_cap : '0);
`ifdef ARB_PERF_CNT_EN
        chk("i_grants", igr, pi);
        chk("d_grants", dgr, pd);
`endif
        if (rearm_i) begin ireq = 1; rearm_i = 0; end
        if (rearm_d) begin dreq = 1; rearm_d = 0; end
        if (rnd) begin
            mrdata = $urandom;
            if (!ireq && $urandom_range(3) == 0) begin
                ireq = 1; iaddr = $urandom;
            end
            if (!dreq && $urandom_range(3) == 0) begin
                dreq = 1; daddr = $urandom; dwdata = $urandom; dwe = $urandom_range(1);
            end
        end
        if (rdy && win_d)  begin dreq = 0; rearm_d = hold_d; end
        if (rdy && !win_d) begin ireq = 0; rearm_i = hold_i; end
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((ireq || dreq || busy) && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < maxc, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) cycle();
        rst_n = 1;
        cycle();

        // Lone I-cache read
        iaddr = 32'h40; mrdata = 32'hDEADBEEF; ireq = 1;
        drain(20);

        // Simultaneous requests: D owns the pointer after reset
        iaddr = 32'h100; daddr = 32'h200; dwe = 0; mrdata = 32'h0BADF00D;
        ireq = 1; dreq = 1;
        drain(40);

        // Both held continuously: winners alternate
        hold_i = 1; hold_d = 1; ireq = 1; dreq = 1; mrdata = 32'h11112222;
        repeat (6 * (LAT + 2)) cycle();
        hold_i = 0; hold_d = 0;
        drain(40);

        // D-cache write-through
        dwe = 1; daddr = 32'h80; dwdata = 32'h12345678; mrdata = 32'hFFFF0000;
        dreq = 1;
        drain(20);
        dwe = 0;

        // Reset during the second access cycle
        iaddr = 32'h300; ireq = 1;
        cycle();
        cycle();
        #2 rst_n = 0;
        #1;
        chk("rst_mem_req", mreq, 0);
        chk("rst_i_ready", irdy, 0);
        chk("rst_d_ready", drdy, 0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1;
        repeat (3) cycle();
        iaddr = 32'h500; daddr = 32'h600; ireq = 1; dreq = 1;
        drain(40);

        // Randomized traffic
        rnd = 1;
        repeat (400) cycle();
        rnd = 0;
        drain(60);

        // MEM_LATENCY=1 instance: lone D read
        d1addr = 32'h55; m1rdata = 32'hA5A5C3C3; d1req = 1;
        @(posedge clk); @(negedge clk);
        chk("l1_req_c1", m1req, 1);
        chk("l1_addr", m1addr, 32'h55);
        chk("l1_rdy_c1", d1rdy, 0);
        m1rdata = 32'h77777777;
        @(posedge clk); @(negedge clk);
        chk("l1_req_c2", m1req, 0);
        chk("l1_rdy_c2", d1rdy, 1);
        chk("l1_rdata", d1rdata, 32'h77777777);
        chk("l1_i_rdy", i1rdy, 0);
        d1req = 0;
        @(posedge clk); @(negedge clk);
        chk("l1_rdy_c3", d1rdy, 0);
        chk("l1_rdata_c3", d1rdata, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
